clock_time_ctrl: RTL and testbench

//  Timekeeping controller for the HH:MM:SS clock. Samples the 1 Hz square wave from the

---
 rtl/clock_time_ctrl.sv | 134 +++++++++++++
 tb/tb_clock_time_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_time_ctrl.sv
// HH:MM:SS timekeeping controller: turns the 1 Hz divider output into a one-cycle tick,
// sequences the time counters and runs the MODE/INC set-mode FSM.
module clock_time_ctrl #(
  parameter bit H24 = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_sec_clk,
  input  logic       i_mode,
  input  logic       i_inc,
  output logic [4:0] o_hh,
  output logic [5:0] o_mm,
  output logic [5:0] o_ss,
  output logic [1:0] o_mode,
  output logic       o_blink,
  output logic       o_wrap
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SET_HH = 2'd1,
    SET_MM = 2'd2,
    SET_SS = 2'd3
  } mode_e;

  localparam logic [4:0] HH_MIN = H24 ? 5'd0  : 5'd1;
  localparam logic [4:0] HH_MAX = H24 ? 5'd23 : 5'd12;
  localparam logic [4:0] HH_RST = H24 ? 5'd0  : 5'd12;
  localparam logic [5:0] MS_MAX = 6'd59;

  logic [2:0] sync_q;
  mode_e      mode_q, mode_d;
  logic [4:0] hh_q, hh_d;
  logic [5:0] mm_q, mm_d;
  logic [5:0] ss_q, ss_d;
  logic       blink_q, blink_d;
  logic       wrap_q, wrap_d;

  logic       tick;
  logic [4:0] hh_cur;
  logic [5:0] mm_cur;
  logic [5:0] ss_cur;

  function automatic logic [4:0] hh_next(input logic [4:0] h);
    return (h == HH_MAX) ? HH_MIN : h + 5'd1;
  endfunction

  function automatic logic [5:0] ms_next(input logic [5:0] v);
    return (v == MS_MAX) ? 6'd0 : v + 6'd1;
  endfunction

  // sync_q[0..1] synchronize the divider output; sync_q[2] delays it once more for edge detect.
  assign tick = sync_q[1] & ~sync_q[2];

  // Defensive range clamp: an illegal field value reloads that field's reset value.
  assign hh_cur = ((hh_q > HH_MAX) || (!H24 && (hh_q == 5'd0))) ? HH_RST : hh_q;
  assign mm_cur = (mm_q > MS_MAX) ? 6'd0 : mm_q;
  assign ss_cur = (ss_q > MS_MAX) ? 6'd0 : ss_q;

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    mode_d = mode_q;
    hh_d   = hh_cur;
    mm_d   = mm_cur;
    ss_d   = ss_cur;
    wrap_d = 1'b0;

    case (mode_q)
      RUN: begin
        if (tick) begin
          ss_d = ms_next(ss_cur);
          if (ss_cur == MS_MAX) begin
            mm_d = ms_next(mm_cur);
            if (mm_cur == MS_MAX) begin
              hh_d   = hh_next(hh_cur);
              wrap_d = (hh_cur == HH_MAX);
            end
          end
        end
        if (i_mode) mode_d = SET_HH;
      end
      SET_HH: begin
        if (i_mode)     mode_d = SET_MM;
        else if (i_inc) hh_d   = hh_next(hh_cur);
      end
      SET_MM: begin
        if (i_mode)     mode_d = SET_SS;
        else if (i_inc) mm_d   = ms_next(mm_cur);
      end
      SET_SS: begin
        // Leaving set mode restarts the time on a whole second.
        if (i_mode) begin
          mode_d = RUN;
          ss_d   = 6'd0;
        end else if (i_inc) begin
          ss_d = ms_next(ss_cur);
        end
      end
      default: mode_d = RUN;
    endcase

    // sync_q[0] is the value s2 takes at this edge, so the registered strobe equals s2.
    blink_d = (mode_d == RUN) ? 1'b1 : sync_q[0];
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sync_q  <= 3'b000;
      mode_q  <= RUN;
      hh_q    <= HH_RST;
      mm_q    <= 6'd0;
      ss_q    <= 6'd0;
      blink_q <= 1'b1;
      wrap_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      sync_q  <= {sync_q[1:0], i_sec_clk};
      mode_q  <= mode_d;
      hh_q    <= hh_d;
      mm_q    <= mm_d;
      ss_q    <= ss_d;
      blink_q <= blink_d;
      wrap_q  <= wrap_d;
    end
  end

  assign o_hh    = hh_q;
  assign o_mm    = mm_q;
  assign o_ss    = ss_q;
  assign o_mode  = mode_q;
  assign o_blink = blink_q;
  assign o_wrap  = wrap_q;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Self-checking bench for clock_time_ctrl: a 24h and a 12h instance share the 1 Hz input
// and are compared against a seconds-of-day reference model.
module tb_clock_time_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sec_clk;
  logic       mode_in [2];
  logic       inc_in  [2];
  logic [4:0] hh      [2];
  logic [5:0] mm      [2];
  logic [5:0] ss      [2];
  logic [1:0] md      [2];
  logic       blink   [2];
  logic       wrap    [2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  clock_time_ctrl #(.H24(1'b1)) u_dut24 (
    .i_clk(clk), .i_rst(rst_n), .i_sec_clk(sec_clk),
    .i_mode(mode_in[0]), .i_inc(inc_in[0]),
    .o_hh(hh[0]), .o_mm(mm[0]), .o_ss(ss[0]),
    .o_mode(md[0]), .o_blink(blink[0]), .o_wrap(wrap[0])
  );

  clock_time_ctrl #(.H24(1'b0)) u_dut12 (
    .i_clk(clk), .i_rst(rst_n), .i_sec_clk(sec_clk),
    .i_mode(mode_in[1]), .i_inc(inc_in[1]),
    .o_hh(hh[1]), .o_mm(mm[1]), .o_ss(ss[1]),
    .o_mode(md[1]), .o_blink(blink[1]), .o_wrap(wrap[1])
  );

  // Reference model: time as seconds into the day (24h) or half-day (12h, index 0 shows 12).
  int tod    [2];
  int m_mode [2];
  bit m_wrap [2];
  bit x_hist [3];   // sec_clk sampled at the last three edges, [0] newest

  function automatic int exp_hh(input int d);
    int h;
    h = tod[d] / 3600;
    return (d == 1 && h == 0) ? 12 : h;
  endfunction
  function automatic int exp_mm(input int d);
    return (tod[d] / 60) % 60;
  endfunction
  function automatic int exp_ss(input int d);
    return tod[d] % 60;
  endfunction
  function automatic bit exp_blink(input int d);
    return (m_mode[d] == 0) ? 1'b1 : x_hist[1];
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      tod[d] = 0; m_mode[d] = 0; m_wrap[d] = 1'b0;
    end
    for (int k = 0; k < 3; k++) x_hist[k] = 1'b0;
  endtask

  task automatic model_field(input int d, input bit upd);
    int nh, h, m, s;
    nh = (d == 0) ? 24 : 12;
    h = tod[d] / 3600; m = (tod[d] / 60) % 60; s = tod[d] % 60;
    m_wrap[d] = 1'b0;
    if (m_mode[d] == 0) begin
      if (upd) begin
        tod[d] = (tod[d] + 1) % (nh * 3600);
        m_wrap[d] = (d == 0) ? (tod[d] == 0) : (tod[d] == 3600);
      end
      if (mode_in[d]) m_mode[d] = 1;
    end else if (mode_in[d]) begin
      if (m_mode[d] == 3) begin
        s = 0; m_mode[d] = 0;
      end else begin
        m_mode[d] = m_mode[d] + 1;
      end
      tod[d] = h * 3600 + m * 60 + s;
    end else if (inc_in[d]) begin
      case (m_mode[d])
        1:       h = (h + 1) % nh;
        2:       m = (m + 1) % 60;
        default: s = (s + 1) % 60;
      endcase
      tod[d] = h * 3600 + m * 60 + s;
    end
  endtask

  // One clock: the model applies the same edge the DUT sees; returns at the falling edge.
  task automatic cycle();
    bit upd;
    @(posedge clk);
    upd = x_hist[1] && !x_hist[2];   // rising edge sampled two edges ago
    for (int d = 0; d < 2; d++) model_field(d, upd);
    x_hist[2] = x_hist[1]; x_hist[1] = x_hist[0]; x_hist[0] = sec_clk;
    @(negedge clk);
  endtask

  task automatic press(input int d, input bit m, input bit i);
    mode_in[d] = m; inc_in[d] = i;
    cycle();
    mode_in[d] = 1'b0; inc_in[d] = 1'b0;
  endtask

  task automatic secs(input int n);
    repeat (n) begin
      sec_clk = 1'b1; cycle(); cycle();
      sec_clk = 1'b0; cycle(); cycle();
    end
  endtask

  // Sets hh:mm:00 through the set-mode FSM; instance d must be in RUN.
  task automatic set_time(input int d, input int th, input int tm);
    int n, nh;
    nh = (d == 0) ? 24 : 12;
    sec_clk = 1'b0;
    repeat (3) cycle();
    press(d, 1'b1, 1'b0);
    n = ((th % nh) - tod[d] / 3600 + nh) % nh;
    repeat (n) press(d, 1'b0, 1'b1);
    press(d, 1'b1, 1'b0);
    n = (tm - (tod[d] / 60) % 60 + 60) % 60;
    repeat (n) press(d, 1'b0, 1'b1);
    press(d, 1'b1, 1'b0);
    press(d, 1'b1, 1'b0);
  endtask

  // One 1 Hz rising edge; captures the outputs right after the update edge.
  task automatic watch_edge(input int d, output int wcnt, output int h, output int m,
                            output int s, output bit w);
    wcnt = 0; h = 0; m = 0; s = 0; w = 1'b0;
    sec_clk = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c == 2) sec_clk = 1'b0;
      cycle();
      if (wrap[d] === 1'b1) wcnt++;
      if (c == 2) begin
        h = int'(hh[d]); m = int'(mm[d]); s = int'(ss[d]); w = wrap[d];
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sec_clk = 1'b0;
    for (int d = 0; d < 2; d++) begin mode_in[d] = 1'b0; inc_in[d] = 1'b0; end
    model_reset();
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++; if (hh[d] !== ((d == 0) ? 5'd0 : 5'd12)) begin errors++; $display("FAIL reset_hh[%0d]: got %0d", d, hh[d]); end
      checks++; if (mm[d] !== 6'd0) begin errors++; $display("FAIL reset_mm[%0d]: got %0d expected 0", d, mm[d]); end
      checks++; if (ss[d] !== 6'd0) begin errors++; $display("FAIL reset_ss[%0d]: got %0d expected 0", d, ss[d]); end
      checks++; if (md[d] !== 2'd0) begin errors++; $display("FAIL reset_mode[%0d]: got %0d expected 0", d, md[d]); end
      checks++; if (blink[d] !== 1'b1) begin errors++; $display("FAIL reset_blink[%0d]: got %b expected 1", d, blink[d]); end
      checks++; if (wrap[d] !== 1'b0) begin errors++; $display("FAIL reset_wrap[%0d]: got %b expected 0", d, wrap[d]); end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_first_tick();
    sec_clk = 1'b1;
    cycle();
    checks++; if (ss[0] !== 6'd0) begin errors++; $display("FAIL tick_e0: ss got %0d expected 0", ss[0]); end
    cycle();
    checks++; if (ss[0] !== 6'd0) begin errors++; $display("FAIL tick_e1: ss got %0d expected 0", ss[0]); end
    cycle();
    checks++; if (ss[0] !== 6'd1) begin errors++; $display("FAIL tick_e2: ss got %0d expected 1", ss[0]); end
    checks++; if (ss[1] !== 6'd1) begin errors++; $display("FAIL tick_e2_12h: ss got %0d expected 1", ss[1]); end
    cycle();
    sec_clk = 1'b0;
    cycle(); cycle();
    checks++; if (ss[0] !== 6'd1) begin errors++; $display("FAIL tick_single: ss got %0d expected 1", ss[0]); end
    secs(2);
    checks++; if (ss[0] !== 6'd3) begin errors++; $display("FAIL tick_three: ss got %0d expected 3", ss[0]); end
    checks++; if (ss[1] !== 6'(exp_ss(1))) begin errors++; $display("FAIL tick_three_12h: ss got %0d expected %0d", ss[1], exp_ss(1)); end
  endtask

  task automatic test_rollover_24();
    int wcnt, h, m, s;
    bit w;
    set_time(0, 23, 59);
    secs(58);
    checks++; if ({hh[0], mm[0], ss[0]} !== {5'd23, 6'd59, 6'd58}) begin errors++; $display("FAIL r24_pre: got %0d:%0d:%0d expected 23:59:58", hh[0], mm[0], ss[0]); end
    secs(1);
    checks++; if ({hh[0], mm[0], ss[0]} !== {5'd23, 6'd59, 6'd59}) begin errors++; $display("FAIL r24_last: got %0d:%0d:%0d expected 23:59:59", hh[0], mm[0], ss[0]); end
    watch_edge(0, wcnt, h, m, s, w);
    checks++; if (h != 0 || m != 0 || s != 0) begin errors++; $display("FAIL r24_wrap_time: got %0d:%0d:%0d expected 0:0:0", h, m, s); end
    checks++; if (w !== 1'b1) begin errors++; $display("FAIL r24_wrap_flag: got %b expected 1", w); end
    checks++; if (wcnt != 1) begin errors++; $display("FAIL r24_wrap_len: got %0d cycles expected 1", wcnt); end
  endtask

  task automatic test_rollover_12();
    int wcnt, h, m, s;
    bit w;
    set_time(1, 12, 59);
    secs(59);
    checks++; if ({hh[1], mm[1], ss[1]} !== {5'd12, 6'd59, 6'd59}) begin errors++; $display("FAIL r12_pre: got %0d:%0d:%0d expected 12:59:59", hh[1], mm[1], ss[1]); end
    watch_edge(1, wcnt, h, m, s, w);
    checks++; if (h != 1 || m != 0 || s != 0) begin errors++; $display("FAIL r12_wrap_time: got %0d:%0d:%0d expected 1:0:0", h, m, s); end
    checks++; if (w !== 1'b1 || wcnt != 1) begin errors++; $display("FAIL r12_wrap_flag: got %b for %0d cycles expected 1 for 1", w, wcnt); end
    set_time(1, 11, 59);
    secs(59);
    watch_edge(1, wcnt, h, m, s, w);
    checks++; if (h != 12 || m != 0 || s != 0) begin errors++; $display("FAIL r12_noon_time: got %0d:%0d:%0d expected 12:0:0", h, m, s); end
    checks++; if (wcnt != 0) begin errors++; $display("FAIL r12_noon_wrap: got %0d wrap cycles expected 0", wcnt); end
  endtask

  task automatic test_set_hh();
    int h0, m0, s0, n_hi, n_lo;
    sec_clk = 1'b0;
    repeat (3) cycle();
    h0 = tod[0] / 3600; m0 = exp_mm(0); s0 = exp_ss(0);
    n_hi = 0; n_lo = 0;
    press(0, 1'b1, 1'b0);
    checks++; if (md[0] !== 2'd1) begin errors++; $display("FAIL sethh_mode: got %0d expected 1", md[0]); end
    for (int i = 0; i < 25; i++) begin
      sec_clk = ((i % 6) < 3);
      press(0, 1'b0, 1'b1);
      if (blink[0] === 1'b1) n_hi++; else n_lo++;
      checks++; if (blink[0] !== exp_blink(0)) begin errors++; $display("FAIL sethh_blink: cycle %0d got %b expected %b", i, blink[0], exp_blink(0)); end
    end
    sec_clk = 1'b0;
    repeat (3) cycle();
    checks++; if (hh[0] !== 5'((h0 + 25) % 24)) begin errors++; $display("FAIL sethh_hh: got %0d expected %0d", hh[0], (h0 + 25) % 24); end
    checks++; if (mm[0] !== 6'(m0) || ss[0] !== 6'(s0)) begin errors++; $display("FAIL sethh_frozen: got %0d:%0d expected %0d:%0d", mm[0], ss[0], m0, s0); end
    checks++; if (n_hi == 0 || n_lo == 0) begin errors++; $display("FAIL sethh_blink_toggle: got %0d high %0d low, expected both nonzero", n_hi, n_lo); end
  endtask

  task automatic test_set_mm_ss();
    int m0, n;
    press(0, 1'b1, 1'b0);
    checks++; if (md[0] !== 2'd2) begin errors++; $display("FAIL setmm_mode: got %0d expected 2", md[0]); end
    m0 = exp_mm(0);
    for (int i = 0; i < 60; i++) begin
      sec_clk = ((i % 4) < 2);
      press(0, 1'b0, 1'b1);
    end
    sec_clk = 1'b0;
    checks++; if (mm[0] !== 6'(m0)) begin errors++; $display("FAIL setmm_x60: got %0d expected %0d", mm[0], m0); end
    press(0, 1'b1, 1'b0);
    checks++; if (md[0] !== 2'd3) begin errors++; $display("FAIL setss_mode: got %0d expected 3", md[0]); end
    n = (30 - exp_ss(0) + 60) % 60;
    repeat (n) press(0, 1'b0, 1'b1);
    checks++; if (ss[0] !== 6'd30) begin errors++; $display("FAIL setss_30: got %0d expected 30", ss[0]); end
    repeat (3) cycle();
    press(0, 1'b1, 1'b0);
    checks++; if (md[0] !== 2'd0 || ss[0] !== 6'd0 || blink[0] !== 1'b1) begin errors++; $display("FAIL setss_exit: got mode %0d ss %0d blink %b expected 0 0 1", md[0], ss[0], blink[0]); end
    checks++; if (hh[0] !== 5'(exp_hh(0)) || mm[0] !== 6'(exp_mm(0))) begin errors++; $display("FAIL setss_exit_hm: got %0d:%0d expected %0d:%0d", hh[0], mm[0], exp_hh(0), exp_mm(0)); end
    secs(1);
    checks++; if (ss[0] !== 6'd1) begin errors++; $display("FAIL setss_resume: got %0d expected 1", ss[0]); end
  endtask

  task automatic test_simultaneous();
    int h0, s0;
    sec_clk = 1'b0;
    repeat (3) cycle();
    press(0, 1'b1, 1'b0);
    h0 = exp_hh(0);
    press(0, 1'b1, 1'b1);
    checks++; if (md[0] !== 2'd2 || hh[0] !== 5'(h0)) begin errors++; $display("FAIL sim_mode_inc: got mode %0d hh %0d expected 2 %0d", md[0], hh[0], h0); end
    press(0, 1'b1, 1'b0);
    press(0, 1'b1, 1'b0);
    s0 = exp_ss(0);
    sec_clk = 1'b1; cycle(); cycle();
    mode_in[0] = 1'b1; cycle(); mode_in[0] = 1'b0; sec_clk = 1'b0;
    checks++; if (ss[0] !== 6'((s0 + 1) % 60) || md[0] !== 2'd1) begin errors++; $display("FAIL sim_tick_mode_run: got ss %0d mode %0d expected %0d 1", ss[0], md[0], (s0 + 1) % 60); end
    press(0, 1'b1, 1'b0);
    press(0, 1'b1, 1'b0);
    repeat (5) press(0, 1'b0, 1'b1);
    checks++; if (ss[0] !== 6'(exp_ss(0)) || md[0] !== 2'd3) begin errors++; $display("FAIL sim_setss: got ss %0d mode %0d expected %0d 3", ss[0], md[0], exp_ss(0)); end
    repeat (3) cycle();
    sec_clk = 1'b1; cycle(); cycle();
    mode_in[0] = 1'b1; cycle(); mode_in[0] = 1'b0; sec_clk = 1'b0;
    checks++; if (ss[0] !== 6'd0 || md[0] !== 2'd0) begin errors++; $display("FAIL sim_tick_mode_setss: got ss %0d mode %0d expected 0 0", ss[0], md[0]); end
    repeat (3) cycle();
    checks++; if (ss[0] !== 6'd0) begin errors++; $display("FAIL sim_no_late_tick: got ss %0d expected 0", ss[0]); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) sec_clk = ~sec_clk;
      for (int d = 0; d < 2; d++) begin
        mode_in[d] = ($urandom_range(0, 29) == 0);
        inc_in[d]  = ($urandom_range(0, 2) == 0);
      end
      cycle();
      for (int d = 0; d < 2; d++) begin
        checks++; if (hh[d] !== 5'(exp_hh(d))) begin errors++; $display("FAIL rnd_hh[%0d] cyc %0d: got %0d expected %0d", d, c, hh[d], exp_hh(d)); end
        checks++; if (mm[d] !== 6'(exp_mm(d))) begin errors++; $display("FAIL rnd_mm[%0d] cyc %0d: got %0d expected %0d", d, c, mm[d], exp_mm(d)); end
        checks++; if (ss[d] !== 6'(exp_ss(d))) begin errors++; $display("FAIL rnd_ss[%0d] cyc %0d: got %0d expected %0d", d, c, ss[d], exp_ss(d)); end
        checks++; if (md[d] !== 2'(m_mode[d])) begin errors++; $display("FAIL rnd_mode[%0d] cyc %0d: got %0d expected %0d", d, c, md[d], m_mode[d]); end
        checks++; if (blink[d] !== exp_blink(d)) begin errors++; $display("FAIL rnd_blink[%0d] cyc %0d: got %b expected %b", d, c, blink[d], exp_blink(d)); end
        checks++; if (wrap[d] !== m_wrap[d]) begin errors++; $display("FAIL rnd_wrap[%0d] cyc %0d: got %b expected %b", d, c, wrap[d], m_wrap[d]); end
      end
    end
    for (int d = 0; d < 2; d++) begin mode_in[d] = 1'b0; inc_in[d] = 1'b0; end
  endtask

  task automatic test_async_reset();
    while (m_mode[0] != 0) press(0, 1'b1, 1'b0);
    set_time(0, 10, 20);
    secs(30);
    press(0, 1'b1, 1'b0);
    press(0, 1'b1, 1'b0);
    checks++; if ({hh[0], mm[0], ss[0], md[0]} !== {5'd10, 6'd20, 6'd30, 2'd2}) begin errors++; $display("FAIL arst_pre: got %0d:%0d:%0d mode %0d expected 10:20:30 mode 2", hh[0], mm[0], ss[0], md[0]); end
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++; if (hh[d] !== ((d == 0) ? 5'd0 : 5'd12) || mm[d] !== 6'd0 || ss[d] !== 6'd0) begin errors++; $display("FAIL arst_time[%0d]: got %0d:%0d:%0d", d, hh[d], mm[d], ss[d]); end
      checks++; if (md[d] !== 2'd0 || blink[d] !== 1'b1 || wrap[d] !== 1'b0) begin errors++; $display("FAIL arst_ctrl[%0d]: got mode %0d blink %b wrap %b expected 0 1 0", d, md[d], blink[d], wrap[d]); end
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_first_tick();
    test_rollover_24();
    test_rollover_12();
    test_set_hh();
    test_set_mm_ss();
    test_simultaneous();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
